// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Posted write buffer between the L2 cache memory-side port and the slow
//   data memory. Dirty-line write-backs are absorbed into a small circular
//   FIFO so that L2 refills are not serialised behind slow memory writes.
//   A write to a line already held is merged into that entry, reads that hit
//   a held line are served from the buffer, and entries drain to memory in
//   FIFO order whenever the upstream side is idle.
//
// Ports
//   clk          system clock
//   proc_reset   asynchronous, active-high reset
//   proc_read    L2 line read request, held until proc_ready
//   proc_write   L2 line write request, held until proc_ready
//   proc_addr    L2 line address (byte address bits [31:4])
//   proc_wdata   L2 write line
//   proc_rdata   read line, valid while proc_ready=1
//   proc_ready   one-cycle completion pulse to L2
//   mem_read     memory read request, held until mem_ready
//   mem_write    memory write request, held until mem_ready
//   mem_addr     memory line address
//   mem_wdata    memory write line
//   mem_rdata    memory read line, valid with mem_ready
//   mem_ready    memory completion pulse
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    RD_MEM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  // Entry storage
  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  // Lookup and decode
  logic [DEPTH-1:0]  hit_vec_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              idle_live_s;
  logic              rd_hit_s;
  logic              rd_miss_s;
  logic              merge_s;
  logic              push_s;
  logic              pop_s;
  logic              drain_go_s;
  logic              ack_go_s;

  // Next values of the registered outputs
  logic              proc_ready_s;
  logic [DATA_W-1:0] proc_rdata_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit_vec_s[g] = valid_r[g] && (addr_r[g] == proc_addr);
  end

  assign hit_s   = |hit_vec_s;
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Encode the hit position; merging guarantees at most one hit, so OR-ing works
  always_comb begin
    hit_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_idx_s = hit_idx_s | ({PTR_W{hit_vec_s[i]}} & PTR_W'(i));
    end
  end

  // The cycle proc_ready is high the requester still holds the old request,
  // so IDLE does nothing in that cycle to avoid serving it twice.
  assign idle_live_s = (state_r == IDLE) && !proc_ready;
  assign rd_hit_s    = idle_live_s && proc_read && hit_s;
  assign rd_miss_s   = idle_live_s && proc_read && !hit_s;
  assign merge_s     = idle_live_s && proc_write && hit_s;
  assign push_s      = idle_live_s && proc_write && !hit_s && !full_s;
  assign drain_go_s  = idle_live_s &&
                       ((proc_write && !hit_s && full_s) ||
                        (!proc_read && !proc_write && !empty_s));
  assign ack_go_s    = rd_hit_s || merge_s || push_s;
  assign pop_s       = (state_r == DRAIN) && mem_ready;

  // State register
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ack_go_s) begin
          state_s = ACK;
        end else if (rd_miss_s) begin
          state_s = RD_MEM;
        end else if (drain_go_s) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      ACK: state_s = IDLE;
      RD_MEM: begin
        if (mem_ready) begin
          state_s = ACK;
        end else begin
          state_s = RD_MEM;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output logic: next values for the output registers
  always_comb begin
    proc_ready_s = 1'b0;
    proc_rdata_s = proc_rdata;
    mem_read_s   = mem_read;
    mem_write_s  = mem_write;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    case (state_r)
      IDLE: begin
        if (rd_hit_s) begin
          proc_rdata_s = data_r[hit_idx_s];
        end else if (rd_miss_s) begin
          mem_read_s = 1'b1;
          mem_addr_s = proc_addr;
        end else if (drain_go_s) begin
          mem_write_s = 1'b1;
          mem_addr_s  = addr_r[head_r];
          mem_wdata_s = data_r[head_r];
        end else begin
          proc_rdata_s = proc_rdata;
        end
      end
      ACK: proc_ready_s = 1'b1;
      RD_MEM: begin
        if (mem_ready) begin
          proc_rdata_s = mem_rdata;
          mem_read_s   = 1'b0;
        end else begin
          mem_read_s = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          mem_write_s = 1'b0;
        end else begin
          mem_write_s = 1'b1;
        end
      end
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      proc_ready <= 1'b0;
      proc_rdata <= {DATA_W{1'b0}};
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      proc_ready <= proc_ready_s;
      proc_rdata <= proc_rdata_s;
      mem_read   <= mem_read_s;
      mem_write  <= mem_write_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
    end
  end

  // FIFO bookkeeping: valid bits, pointers and occupancy
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (push_s) begin
      valid_r[tail_r] <= 1'b1;
      tail_r          <= tail_r + PTR_W'(1'b1);
      count_r         <= count_r + CNT_W'(1'b1);
    end else if (pop_s) begin
      valid_r[head_r] <= 1'b0;
      head_r          <= head_r + PTR_W'(1'b1);
      count_r         <= count_r - CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry payload: new lines go to the tail, merges overwrite the hit entry
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_r[tail_r] <= proc_addr;
      data_r[tail_r] <= proc_wdata;
    end else if (merge_s) begin
      data_r[hit_idx_s] <= proc_wdata;
    end else begin
      data_r[hit_idx_s] <= data_r[hit_idx_s];
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer. Stimulus pushes expected
// upstream responses and expected memory transactions into queues; a monitor
// pops and compares them whenever the DUT presents proc_ready or completes a
// memory handshake. A simple memory responder answers mem_read/mem_write
// after a programmable delay, or withholds mem_ready while mem_hold is set.
module tb_dmem_write_buffer;

  typedef struct packed {
    logic         rd;
    logic [127:0] data;
  } pe_t;

  typedef struct packed {
    logic [27:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [27:0]  proc_addr;
  logic [127:0] proc_wdata;
  logic [127:0] proc_rdata;
  logic         proc_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  bit           mem_hold;
  int           mem_delay;
  logic [127:0] rd_value;

  int n_checks = 0;
  int n_pass   = 0;

  pe_t         sb_proc[$];
  wr_t         sb_wr[$];
  logic [27:0] sb_rd[$];

  dmem_write_buffer #(.DEPTH(4), .ADDR_W(28), .DATA_W(128)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_ready (proc_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_checks++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask

  function automatic logic [127:0] mk(input logic [27:0] a);
    return {a, 4'h0, 32'h0BAD_F00D, a, 4'h5, 32'h1234_5678};
  endfunction

  task automatic exp_wr(input logic [27:0] a, input logic [127:0] d);
    sb_wr.push_back('{addr: a, data: d});
  endtask

  task automatic issue(input bit rd, input logic [27:0] a, input logic [127:0] d,
                       input logic [127:0] exp);
    sb_proc.push_back('{rd: rd, data: exp});
    proc_read  = rd;
    proc_write = ~rd;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  // Wait for proc_ready, optionally check request-to-ready latency, then drop the request
  task automatic wait_ack(input int lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (proc_ready) got = 1'b1;
    end
    chk("ack_seen", 128'(got), 128'(1'b1));
    if (got && lat >= 0) chk("ack_latency", 128'(n - 1), 128'(lat));
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    mem_hold = 1'b0;
    while (sb_wr.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 128'(sb_wr.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Memory responder
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if ((mem_read || mem_write) && !mem_hold) begin
        if (wait_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd_value;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    pe_t pe;
    wr_t we;
    logic [27:0] ra;
    if (!proc_reset) begin
      if (proc_ready) begin
        if (sb_proc.size() == 0) bad("proc_ready_unexpected");
        else begin
          pe = sb_proc.pop_front();
          if (pe.rd) chk("proc_rdata", proc_rdata, pe.data);
        end
      end
      if (mem_read && mem_write) bad("mem_read_and_write");
      if (mem_write && mem_ready) begin
        if (sb_wr.size() == 0) bad("mem_write_unexpected");
        else begin
          we = sb_wr.pop_front();
          chk("mem_write_addr", 128'(mem_addr), 128'(we.addr));
          chk("mem_write_data", mem_wdata, we.data);
        end
      end
      if (mem_read && mem_ready) begin
        if (sb_rd.size() == 0) bad("mem_read_unexpected");
        else begin
          ra = sb_rd.pop_front();
          chk("mem_read_addr", 128'(mem_addr), 128'(ra));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 28'd0;
    proc_wdata = 128'd0;
    mem_hold   = 1'b1;
    mem_delay  = 0;
    rd_value   = 128'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_proc_ready", 128'(proc_ready), 128'(1'b0));
    chk("rst_proc_rdata", proc_rdata, 128'd0);
    chk("rst_mem_read",   128'(mem_read), 128'(1'b0));
    chk("rst_mem_write",  128'(mem_write), 128'(1'b0));
    chk("rst_mem_addr",   128'(mem_addr), 128'd0);
    chk("rst_mem_wdata",  mem_wdata, 128'd0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    @(posedge clk);
    #1;

    // Write then read the same line; memory withheld, read served from buffer
    issue(1'b0, 28'h0000010, {32{4'hA}}, 128'd0);
    wait_ack(2);
    issue(1'b1, 28'h0000010, 128'd0, {32{4'hA}});
    wait_ack(2);
    exp_wr(28'h0000010, {32{4'hA}});
    wait_drain();

    // Write merge: one drain with the second data
    mem_hold = 1'b1;
    issue(1'b0, 28'h20, 128'h1111_0000_0000_0000_0000_0000_0000_0001, 128'd0);
    wait_ack(2);
    issue(1'b0, 28'h20, 128'h2222_0000_0000_0000_0000_0000_0000_0002, 128'd0);
    wait_ack(2);
    exp_wr(28'h20, 128'h2222_0000_0000_0000_0000_0000_0000_0002);
    wait_drain();

    // Full buffer stall: fifth write waits for one drain
    mem_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, 28'(i), mk(28'(i)), 128'd0);
      wait_ack(2);
    end
    for (int i = 1; i <= 5; i++) exp_wr(28'(i), mk(28'(i)));
    issue(1'b0, 28'h5, mk(28'h5), 128'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_ready", 128'(proc_ready), 128'(1'b0));
    end
    chk("stall_mem_write", 128'(mem_write), 128'(1'b1));
    chk("stall_mem_addr", 128'(mem_addr), 128'h1);
    mem_hold = 1'b0;
    wait_ack(-1);
    chk("stall_drained_first", 128'(sb_wr.size()), 128'(4));
    wait_drain();

    // Read miss while a write is buffered
    mem_hold = 1'b1;
    issue(1'b0, 28'h30, mk(28'h30), 128'd0);
    wait_ack(2);
    mem_delay = 10;
    rd_value  = 128'h1234;
    sb_rd.push_back(28'h40);
    exp_wr(28'h30, mk(28'h30));
    mem_hold = 1'b0;
    issue(1'b1, 28'h40, 128'd0, 128'h1234);
    wait_ack(-1);
    chk("miss_rd_done", 128'(sb_rd.size()), 128'(0));
    chk("miss_wr_still_held", 128'(sb_wr.size()), 128'(1));
    mem_delay = 0;
    wait_drain();

    // Drain order across pointer wrap
    for (int grp = 0; grp < 2; grp++) begin
      mem_hold = 1'b1;
      for (int i = 1; i <= 3; i++) begin
        issue(1'b0, 28'(grp * 3 + i), mk(28'(grp * 3 + i)), 128'd0);
        wait_ack(2);
      end
      for (int i = 1; i <= 3; i++) exp_wr(28'(grp * 3 + i), mk(28'(grp * 3 + i)));
      wait_drain();
    end
    rd_value = 128'hFEED;
    sb_rd.push_back(28'h6);
    issue(1'b1, 28'h6, 128'd0, 128'hFEED);
    wait_ack(-1);

    // Reset in the middle of a drain
    mem_hold = 1'b1;
    issue(1'b0, 28'h77, mk(28'h77), 128'd0);
    wait_ack(2);
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_write", 128'(mem_write), 128'(1'b1));
    chk("pre_rst_mem_addr", 128'(mem_addr), 128'h77);
    #2;
    proc_reset = 1'b1;
    #1;
    chk("async_rst_mem_write", 128'(mem_write), 128'(1'b0));
    chk("async_rst_proc_ready", 128'(proc_ready), 128'(1'b0));
    chk("async_rst_mem_addr", 128'(mem_addr), 128'd0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    @(posedge clk);
    #1;
    rd_value = 128'hBEEF_CAFE;
    sb_rd.push_back(28'h77);
    mem_hold = 1'b0;
    issue(1'b1, 28'h77, 128'd0, 128'hBEEF_CAFE);
    wait_ack(3);
    repeat (20) @(posedge clk);
    #1;

    chk("end_proc_queue", 128'(sb_proc.size()), 128'(0));
    chk("end_wr_queue", 128'(sb_wr.size()), 128'(0));
    chk("end_rd_queue", 128'(sb_rd.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
